// File: rtl/stopwatch_pkg.sv
// Shared types and limits for the lap stopwatch: time record, FSM states, field maxima.
package stopwatch_pkg;

    localparam int unsigned MS_MAX     = 999;
    localparam int unsigned SEC_MAX    = 59;
    localparam int unsigned MIN_MAX    = 59;
    localparam int unsigned TICK_HZ    = 1000;
    localparam int unsigned HOUR_W_MAX = 8;

    typedef struct packed {
        logic [HOUR_W_MAX-1:0] hour;
        logic [5:0]            min;
        logic [5:0]            sec;
        logic [9:0]            ms;
    } time_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sw_state_t;

    function automatic logic is_zero(input time_t t);
        return (t == '0);
    endfunction

    function automatic logic is_one_ms(input time_t t);
        return (t.hour == '0) && (t.min == 6'd0) && (t.sec == 6'd0) && (t.ms == 10'd1);
    endfunction

endpackage

// File: rtl/lap_fifo.sv
// Synchronous FIFO with registered head; a push and pop in the same cycle both succeed even when full.
module lap_fifo #(
    parameter int unsigned WIDTH = 27,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full_c,
    output logic             valid,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push_c;
    logic             do_pop_c;

    assign full_c = (count_q == CNT_W'(DEPTH));

    always_comb begin
        do_pop_c  = pop && (count_q != '0) && !flush;
        do_push_c = push && (!full_c || do_pop_c) && !flush;
        wr_d      = wr_q + PTR_W'(do_push_c);
        rd_d      = rd_q + PTR_W'(do_pop_c);
        count_d   = count_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
        valid_d   = (count_d != '0);
        // A push into an (effectively) empty FIFO becomes the head directly.
        if (count_d == '0) begin
            head_d = '0;
        end else if (do_push_c && ((count_q - CNT_W'(do_pop_c)) == '0)) begin
            head_d = push_data;
        end else begin
            head_d = mem_q[rd_d];
        end
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
            valid_d = 1'b0;
            head_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem_q[wr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            head_q  <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            valid_q <= valid_d;
            head_q  <= head_d;
        end
    end

    assign valid = valid_q;
    assign head  = head_q;

endmodule

// File: rtl/pos_edge_det.sv
// Rising-edge detector: registered one-cycle pulse, one cycle after the input rises.
module pos_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic prev_q;
    logic pulse_q;
    logic pulse_d;

    always_comb begin
        pulse_d = din & ~prev_q;
    end

    // History tracks the live level during reset so a button held across release is not an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q  <= din;
            pulse_q <= 1'b0;
        end else begin
            prev_q  <= din;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/lap_stopwatch.sv
// Stopwatch/timer with hour field, up/down modes and a lap FIFO, advanced by an internal 1 kHz enable.
module lap_stopwatch
    import stopwatch_pkg::*;
#(
    parameter  int unsigned CLK_FREQ_HZ = 1000,
    parameter  int unsigned MAX_HOURS   = 24,
    parameter  int unsigned LAP_DEPTH   = 4,
    localparam int unsigned HOUR_W      = $clog2(MAX_HOURS),
    localparam int unsigned LAP_W       = HOUR_W + 22
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              lap,
    input  logic              clear,
    input  logic              count_down,
    input  logic [HOUR_W-1:0] preset_hour,
    input  logic [5:0]        preset_min,
    input  logic [5:0]        preset_sec,
    output logic [HOUR_W-1:0] hour_out,
    output logic [5:0]        min_out,
    output logic [5:0]        sec_out,
    output logic [9:0]        ms_out,
    output logic              running,
    output logic              expired,
    output logic              lap_valid,
    output logic [LAP_W-1:0]  lap_data,
    input  logic              lap_ready,
    output logic              lap_overflow
);

    localparam int unsigned DIV       = CLK_FREQ_HZ / TICK_HZ;
    localparam int unsigned PRESC_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned HOUR_LAST = MAX_HOURS - 1;

    sw_state_t          state_q, state_d;
    time_t              time_q, time_d;
    logic               mode_q, mode_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               expired_q, expired_d;
    logic               overflow_q, overflow_d;

    logic start_ev, stop_ev, lap_ev, clear_ev;
    logic tick_c;
    logic fifo_push_c, fifo_pop_c, fifo_flush_c, fifo_full_c;
    logic [LAP_W-1:0] lap_word_c;
    time_t time_up_c, time_dn_c, preset_c;

    pos_edge_det u_start_det (.clk(clk), .reset(reset), .din(start), .pulse(start_ev));
    pos_edge_det u_stop_det  (.clk(clk), .reset(reset), .din(stop),  .pulse(stop_ev));
    pos_edge_det u_lap_det   (.clk(clk), .reset(reset), .din(lap),   .pulse(lap_ev));
    pos_edge_det u_clear_det (.clk(clk), .reset(reset), .din(clear), .pulse(clear_ev));

    lap_fifo #(
        .WIDTH (LAP_W),
        .DEPTH (LAP_DEPTH)
    ) u_lap_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (fifo_flush_c),
        .push      (fifo_push_c),
        .push_data (lap_word_c),
        .pop       (fifo_pop_c),
        .full_c    (fifo_full_c),
        .valid     (lap_valid),
        .head      (lap_data)
    );

    assign tick_c     = (state_q == RUN) && (presc_q == PRESC_W'(DIV - 1));
    assign fifo_pop_c = lap_ready && lap_valid;
    assign lap_word_c = {time_q.hour[HOUR_W-1:0], time_q.min, time_q.sec, time_q.ms};

    // Presets are clamped so a loaded field never starts above its limit.
    always_comb begin
        preset_c      = '0;
        preset_c.hour = (8'(preset_hour) > 8'(HOUR_LAST)) ? 8'(HOUR_LAST) : 8'(preset_hour);
        preset_c.min  = (preset_min > 6'(MIN_MAX)) ? 6'(MIN_MAX) : preset_min;
        preset_c.sec  = (preset_sec > 6'(SEC_MAX)) ? 6'(SEC_MAX) : preset_sec;
    end

    // Count-up successor: compare with the limit first, then wrap or increment.
    always_comb begin
        time_up_c = time_q;
        if (time_q.ms == 10'(MS_MAX)) begin
            time_up_c.ms = '0;
            if (time_q.sec == 6'(SEC_MAX)) begin
                time_up_c.sec = '0;
                if (time_q.min == 6'(MIN_MAX)) begin
                    time_up_c.min = '0;
                    if (time_q.hour == 8'(HOUR_LAST)) begin
                        time_up_c.hour = '0;
                    end else begin
                        time_up_c.hour = time_q.hour + 8'd1;
                    end
                end else begin
                    time_up_c.min = time_q.min + 6'd1;
                end
            end else begin
                time_up_c.sec = time_q.sec + 6'd1;
            end
        end else begin
            time_up_c.ms = time_q.ms + 10'd1;
        end
    end

    // Count-down successor with borrows.
    always_comb begin
        time_dn_c = time_q;
        if (time_q.ms == 10'd0) begin
            time_dn_c.ms = 10'(MS_MAX);
            if (time_q.sec == 6'd0) begin
                time_dn_c.sec = 6'(SEC_MAX);
                if (time_q.min == 6'd0) begin
                    time_dn_c.min = 6'(MIN_MAX);
                    if (time_q.hour == '0) begin
                        time_dn_c.hour = 8'(HOUR_LAST);
                    end else begin
                        time_dn_c.hour = time_q.hour - 8'd1;
                    end
                end else begin
                    time_dn_c.min = time_q.min - 6'd1;
                end
            end else begin
                time_dn_c.sec = time_q.sec - 6'd1;
            end
        end else begin
            time_dn_c.ms = time_q.ms - 10'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        time_d       = time_q;
        mode_d       = mode_q;
        presc_d      = presc_q;
        expired_d    = 1'b0;
        overflow_d   = overflow_q;
        fifo_push_c  = 1'b0;
        fifo_flush_c = 1'b0;

        if (tick_c) begin
            if (!mode_q) begin
                time_d = time_up_c;
            end else if (is_one_ms(time_q)) begin
                time_d    = '0;
                state_d   = IDLE;
                expired_d = 1'b1;
            end else begin
                time_d = time_dn_c;
            end
        end

        // Lap captures the pre-tick registered time.
        if (lap_ev && (state_q == RUN)) begin
            fifo_push_c = 1'b1;
            if (fifo_full_c && !fifo_pop_c) begin
                overflow_d = 1'b1;
            end
        end

        if (stop_ev) begin
            state_d = IDLE;
        end else if (start_ev && (state_q == IDLE)) begin
            if (!(count_down && is_zero(time_q))) begin
                state_d = RUN;
                mode_d  = count_down;
            end
        end

        if (clear_ev) begin
            state_d      = IDLE;
            time_d       = preset_c;
            expired_d    = 1'b0;
            overflow_d   = 1'b0;
            fifo_push_c  = 1'b0;
            fifo_flush_c = 1'b1;
        end

        if ((state_q == RUN) && (state_d == RUN)) begin
            presc_d = tick_c ? '0 : presc_q + PRESC_W'(1);
        end else begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            time_q     <= '0;
            mode_q     <= 1'b0;
            presc_q    <= '0;
            expired_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            time_q     <= time_d;
            mode_q     <= mode_d;
            presc_q    <= presc_d;
            expired_q  <= expired_d;
            overflow_q <= overflow_d;
        end
    end

    assign hour_out     = time_q.hour[HOUR_W-1:0];
    assign min_out      = time_q.min;
    assign sec_out      = time_q.sec;
    assign ms_out       = time_q.ms;
    assign running      = (state_q == RUN);
    assign expired      = expired_q;
    assign lap_overflow = overflow_q;

endmodule
